id_stage_pipe: RTL and testbench
================================

Name: id_stage_pipe

Overview:
Parametrised, pipelined successor to the current instruction-decode stage of the MUSA core. It holds the register file with a write-back port and write-before-read bypass, and decodes the opcode into control bits. It detects load-use hazards and inserts bubbles. Results are captured in an ID/EX pipeline register with a valid/stall/flush handshake, so decode is decoupled from IF and EX.

Parameters:
DATA_W, 32, datapath and register width in bits (16..64).
REG_COUNT, 32, number of architectural registers; one of 8, 16 or 32.
BYPASS_EN, 1, when 1 a same-cycle write-back is forwarded to the read ports.

Ports:
clk  in  1  core clock, all state updates on rising edge
rst  in  1  synchronous, active-high reset
if_valid  in  1  IF presents a valid instruction
if_instr  in  32  instruction word
if_pc  in  32  PC of if_instr
id_ready  out  1  ID accepts if_instr this cycle
wb_en  in  1  write-back enable
wb_addr  in  5  write-back register index
wb_data  in  DATA_W  write-back data
ex_stall  in  1  EX cannot accept; hold ID/EX
ex_flush  in  1  squash ID/EX and the instruction in ID (taken branch or jump)
ex_valid  out  1  ID/EX holds a valid instruction
ex_pc  out  32  registered PC
ex_rs_data, ex_rt_data  out  DATA_W  registered operands
ex_imm  out  DATA_W  sign-extended instr[15:0]
ex_rs, ex_rt, ex_dest  out  5  source indices; destination after the RegDst mux
ex_jump_target  out  32  {if_pc[31:28], instr[25:0], 2'b00}
ex_branch, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_alu_src, ex_reg_write, ex_jump, ex_illegal  out  1  registered control bits
ex_alu_op  out  2  00 add, 01 sub, 10 funct-decoded

Behaviour:
- Reset:
  - All ID/EX outputs go to 0; ex_valid=0.
  - All registers clear to 0.
  - id_ready=0 during the reset cycle.
- Register file:
  - Register 0 always reads 0; writes to it are ignored.
  - An index >= REG_COUNT reads 0; writes to it are ignored.
  - Writes occur on the clock edge when wb_en=1.
  - Reads are combinational.
  - When BYPASS_EN=1 and wb_en=1 and wb_addr==read index (nonzero, in range), the read returns wb_data.
- Decode (combinational, from instr[31:26]):
  - 0x00 R-type: reg_write=1, RegDst=rd, alu_op=10.
  - 0x23 lw: mem_read=1, mem_to_reg=1, alu_src=1, reg_write=1, dest=rt, alu_op=00.
  - 0x2B sw: mem_write=1, alu_src=1, alu_op=00.
  - 0x04 beq: branch=1, alu_op=01.
  - 0x08 addi: alu_src=1, reg_write=1, dest=rt, alu_op=00.
  - 0x02 j: jump=1.
  - Any other opcode: all control bits 0, ex_illegal=1. The instruction still flows with ex_valid=1.
- Load-use hazard:
  - hazard = ex_valid & ex_mem_read & ex_dest!=0 & if_valid & (ex_dest==rs & uses_rs | ex_dest==rt & uses_rt).
  - uses_rs holds for every opcode except j.
  - uses_rt holds for R-type, beq and sw.
- Per-cycle priority, evaluated only when not in reset:
  1. ex_flush: ex_valid<=0, id_ready=1; the incoming instruction is consumed and discarded.
  2. ex_stall: ID/EX holds all fields, id_ready=0.
  3. hazard: bubble (ex_valid<=0, ID/EX control bits <=0), id_ready=0. IF must hold its instruction.
  4. if_valid: load ID/EX with the decoded instruction, ex_valid<=1, id_ready=1.
  5. Otherwise: ex_valid<=0, id_ready=1.
- Latency: one cycle from acceptance to ex_valid.
- Throughput: one instruction per cycle without hazards.
- A hazard costs exactly one bubble. The stall releases the next cycle because ex_mem_read drops when the bubble enters.
- id_ready depends on ex_stall, ex_flush and hazard. This is a combinational path to IF and is accepted.
- A write-back in the same cycle as a hazard stall still updates the register file.
- Reset asserted mid-stall clears everything; no instruction survives reset.

Decomposition:
- Shared package musa_pkg:
  - opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J);
  - ALU_OP encodings;
  - a control-bundle struct, or a localparam field-index set.
- Sub-module reg_file_bypass (parameters DATA_W, REG_COUNT, BYPASS_EN; two read ports, one write port).
- Decode and hazard logic stay inline in id_stage_pipe.

Test Plan:
- Reset: rst=1 for 2 cycles, then read r1..r31 via R-type instructions -> all operands 0, ex_valid=0 during reset.
- Write-back and bypass: wb_en=1, wb_addr=5, wb_data=0xDEADBEEF, with if_instr=add r3,r5,r0 in the same cycle -> next cycle ex_rs_data=0xDEADBEEF. With BYPASS_EN=0 -> ex_rs_data=0.
- Load-use: lw r2,0(r1) followed by add r4,r2,r3 -> one cycle with id_ready=0 and an ex_valid=0 bubble; add enters ID/EX on the following cycle with ex_dest=4.
- No false hazard: lw r2 then addi r6,r7,5 with rt=2 -> no stall (addi does not use rt); ex_imm=5.
- Stall vs flush: ex_stall=1 for 3 cycles -> ID/EX fields unchanged and id_ready=0. Then ex_flush=1 together with ex_stall=1 -> ex_valid=0 next cycle and id_ready=1.
- Illegal and jump:
  - opcode 0x3F -> ex_valid=1, ex_illegal=1, other controls 0.
  - j 0x0000040 at pc 0x10000000 -> ex_jump=1, ex_jump_target=0x10000100.

Source files
------------

// File: rtl/musa_pkg.sv
// Shared MUSA definitions: opcodes, ALU operation encodings and the decoded
// control bundle that the ID stage produces.
package musa_pkg;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   localparam logic [1:0] ALU_ADD   = 2'b00;
   localparam logic [1:0] ALU_SUB   = 2'b01;
   localparam logic [1:0] ALU_FUNCT = 2'b10;

   typedef struct packed {
      logic       branch;
      logic       mem_read;
      logic       mem_write;
      logic       mem_to_reg;
      logic       alu_src;
      logic       reg_write;
      logic       jump;
      logic       illegal;
      logic       reg_dst;   // 1: destination is rd, 0: rt
      logic       uses_rs;
      logic       uses_rt;
      logic [1:0] alu_op;
   } ctrl_t;

   function automatic ctrl_t decode_op(input logic [5:0] op);
      ctrl_t c;
      c = '0;
      case (op)
         OP_RTYPE: begin
            c.reg_write = 1'b1;
            c.reg_dst   = 1'b1;
            c.alu_op    = ALU_FUNCT;
            c.uses_rs   = 1'b1;
            c.uses_rt   = 1'b1;
         end
         OP_LW: begin
            c.mem_read   = 1'b1;
            c.mem_to_reg = 1'b1;
            c.alu_src    = 1'b1;
            c.reg_write  = 1'b1;
            c.alu_op     = ALU_ADD;
            c.uses_rs    = 1'b1;
         end
         OP_SW: begin
            c.mem_write = 1'b1;
            c.alu_src   = 1'b1;
            c.alu_op    = ALU_ADD;
            c.uses_rs   = 1'b1;
            c.uses_rt   = 1'b1;
         end
         OP_BEQ: begin
            c.branch  = 1'b1;
            c.alu_op  = ALU_SUB;
            c.uses_rs = 1'b1;
            c.uses_rt = 1'b1;
         end
         OP_ADDI: begin
            c.alu_src   = 1'b1;
            c.reg_write = 1'b1;
            c.alu_op    = ALU_ADD;
            c.uses_rs   = 1'b1;
         end
         OP_J: begin
            c.jump = 1'b1;
         end
         default: begin
            // Unknown opcodes still flow down the pipe, flagged as illegal.
            c.illegal = 1'b1;
            c.uses_rs = 1'b1;
         end
      endcase
      return c;
   endfunction

endpackage

// File: rtl/reg_file_bypass.sv
// Architectural register file: one write port, two combinational read ports,
// r0 hard-wired to zero, optional write-to-read forwarding.
module reg_file_bypass
   import musa_pkg::*;
#(
   parameter int DATA_W    = 32,
   parameter int REG_COUNT = 32,
   parameter int BYPASS_EN = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_en,
   input  logic [4:0]        wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic [4:0]        rd_addr_a,
   output logic [DATA_W-1:0] rd_data_a,
   input  logic [4:0]        rd_addr_b,
   output logic [DATA_W-1:0] rd_data_b
);

   localparam int AW = $clog2(REG_COUNT);

   logic [DATA_W-1:0] regs_reg [REG_COUNT];
   logic [4:0]        rd_addr  [2];
   logic [DATA_W-1:0] rd_data  [2];

   assign rd_addr[0] = rd_addr_a;
   assign rd_addr[1] = rd_addr_b;
   assign rd_data_a  = rd_data[0];
   assign rd_data_b  = rd_data[1];

   genvar gi;
   generate
      for (gi = 0; gi < REG_COUNT; gi++) begin : g_reg
         always_ff @(posedge clk) begin
            if (rst)
               regs_reg[gi] <= '0;
            else if (wr_en && (gi != 0) && (wr_addr == 5'(gi)))
               regs_reg[gi] <= wr_data;
         end
      end

      for (gi = 0; gi < 2; gi++) begin : g_rd
         always_comb begin
            rd_data[gi] = '0;
            if ((rd_addr[gi] != 5'd0) && (int'(rd_addr[gi]) < REG_COUNT)) begin
               if ((BYPASS_EN != 0) && wr_en && (wr_addr == rd_addr[gi]))
                  rd_data[gi] = wr_data;
               else
                  rd_data[gi] = regs_reg[rd_addr[gi][AW-1:0]];
            end
         end
      end
   endgenerate

endmodule

// File: rtl/id_stage_pipe.sv
// MUSA instruction-decode stage: register read, opcode decode, load-use
// bubble insertion and the ID/EX pipeline register.
module id_stage_pipe
   import musa_pkg::*;
#(
   parameter int DATA_W    = 32,
   parameter int REG_COUNT = 32,
   parameter int BYPASS_EN = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_valid,
   input  logic [31:0]       if_instr,
   input  logic [31:0]       if_pc,
   output logic              id_ready,
   input  logic              wb_en,
   input  logic [4:0]        wb_addr,
   input  logic [DATA_W-1:0] wb_data,
   input  logic              ex_stall,
   input  logic              ex_flush,
   output logic              ex_valid,
   output logic [31:0]       ex_pc,
   output logic [DATA_W-1:0] ex_rs_data,
   output logic [DATA_W-1:0] ex_rt_data,
   output logic [DATA_W-1:0] ex_imm,
   output logic [4:0]        ex_rs,
   output logic [4:0]        ex_rt,
   output logic [4:0]        ex_dest,
   output logic [31:0]       ex_jump_target,
   output logic              ex_branch,
   output logic              ex_mem_read,
   output logic              ex_mem_write,
   output logic              ex_mem_to_reg,
   output logic              ex_alu_src,
   output logic              ex_reg_write,
   output logic              ex_jump,
   output logic              ex_illegal,
   output logic [1:0]        ex_alu_op
);

   logic [4:0]        rs, rt, rd, dest;
   logic [DATA_W-1:0] rs_data, rt_data, imm_ext;
   ctrl_t             ctrl;
   logic              hazard;

   assign rs      = if_instr[25:21];
   assign rt      = if_instr[20:16];
   assign rd      = if_instr[15:11];
   assign ctrl    = decode_op(if_instr[31:26]);
   assign dest    = ctrl.reg_dst ? rd : rt;
   assign imm_ext = DATA_W'($signed(if_instr[15:0]));

   reg_file_bypass #(
      .DATA_W    (DATA_W),
      .REG_COUNT (REG_COUNT),
      .BYPASS_EN (BYPASS_EN)
   ) u_rf (
      .clk       (clk),
      .rst       (rst),
      .wr_en     (wb_en),
      .wr_addr   (wb_addr),
      .wr_data   (wb_data),
      .rd_addr_a (rs),
      .rd_data_a (rs_data),
      .rd_addr_b (rt),
      .rd_data_b (rt_data)
   );

   assign hazard = ex_valid && ex_mem_read && (ex_dest != 5'd0) && if_valid &&
                   (((ex_dest == rs) && ctrl.uses_rs) || ((ex_dest == rt) && ctrl.uses_rt));

   // Flush always drains the incoming instruction, even while EX is stalled.
   assign id_ready = !rst && (ex_flush || (!ex_stall && !hazard));

   always_ff @(posedge clk) begin
      if (rst) begin
         ex_valid       <= 1'b0;
         ex_pc          <= '0;
         ex_rs_data     <= '0;
         ex_rt_data     <= '0;
         ex_imm         <= '0;
         ex_rs          <= '0;
         ex_rt          <= '0;
         ex_dest        <= '0;
         ex_jump_target <= '0;
         ex_branch      <= 1'b0;
         ex_mem_read    <= 1'b0;
         ex_mem_write   <= 1'b0;
         ex_mem_to_reg  <= 1'b0;
         ex_alu_src     <= 1'b0;
         ex_reg_write   <= 1'b0;
         ex_jump        <= 1'b0;
         ex_illegal     <= 1'b0;
         ex_alu_op      <= '0;
      end else if (ex_flush) begin
         ex_valid <= 1'b0;
      end else if (ex_stall) begin
         ex_valid <= ex_valid;
      end else if (hazard) begin
         ex_valid      <= 1'b0;
         ex_branch     <= 1'b0;
         ex_mem_read   <= 1'b0;
         ex_mem_write  <= 1'b0;
         ex_mem_to_reg <= 1'b0;
         ex_alu_src    <= 1'b0;
         ex_reg_write  <= 1'b0;
         ex_jump       <= 1'b0;
         ex_illegal    <= 1'b0;
         ex_alu_op     <= '0;
      end else if (if_valid) begin
         ex_valid       <= 1'b1;
         ex_pc          <= if_pc;
         ex_rs_data     <= rs_data;
         ex_rt_data     <= rt_data;
         ex_imm         <= imm_ext;
         ex_rs          <= rs;
         ex_rt          <= rt;
         ex_dest        <= dest;
         ex_jump_target <= {if_pc[31:28], if_instr[25:0], 2'b00};
         ex_branch      <= ctrl.branch;
         ex_mem_read    <= ctrl.mem_read;
         ex_mem_write   <= ctrl.mem_write;
         ex_mem_to_reg  <= ctrl.mem_to_reg;
         ex_alu_src     <= ctrl.alu_src;
         ex_reg_write   <= ctrl.reg_write;
         ex_jump        <= ctrl.jump;
         ex_illegal     <= ctrl.illegal;
         ex_alu_op      <= ctrl.alu_op;
      end else begin
         ex_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_id_stage_pipe.sv
// Directed bench for id_stage_pipe; a second instance with forwarding
// disabled shares all inputs so both register-file variants are exercised.
module tb_id_stage_pipe;
   import musa_pkg::*;

   logic        clk;
   logic        rst;
   logic        if_valid;
   logic [31:0] if_instr;
   logic [31:0] if_pc;
   logic        wb_en;
   logic [4:0]  wb_addr;
   logic [31:0] wb_data;
   logic        ex_stall;
   logic        ex_flush;

   logic        id_ready, ex_valid;
   logic [31:0] ex_pc, ex_rs_data, ex_rt_data, ex_imm, ex_jump_target;
   logic [4:0]  ex_rs, ex_rt, ex_dest;
   logic        ex_branch, ex_mem_read, ex_mem_write, ex_mem_to_reg;
   logic        ex_alu_src, ex_reg_write, ex_jump, ex_illegal;
   logic [1:0]  ex_alu_op;

   logic        nb_id_ready, nb_ex_valid;
   logic [31:0] nb_ex_pc, nb_ex_rs_data, nb_ex_rt_data, nb_ex_imm, nb_ex_jump_target;
   logic [4:0]  nb_ex_rs, nb_ex_rt, nb_ex_dest;
   logic        nb_ex_branch, nb_ex_mem_read, nb_ex_mem_write, nb_ex_mem_to_reg;
   logic        nb_ex_alu_src, nb_ex_reg_write, nb_ex_jump, nb_ex_illegal;
   logic [1:0]  nb_ex_alu_op;

   int total = 0;
   int bad   = 0;

   id_stage_pipe #(.DATA_W(32), .REG_COUNT(32), .BYPASS_EN(1)) dut (
      .clk(clk), .rst(rst), .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
      .id_ready(id_ready), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
      .ex_stall(ex_stall), .ex_flush(ex_flush), .ex_valid(ex_valid), .ex_pc(ex_pc),
      .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data), .ex_imm(ex_imm),
      .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_dest(ex_dest), .ex_jump_target(ex_jump_target),
      .ex_branch(ex_branch), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
      .ex_mem_to_reg(ex_mem_to_reg), .ex_alu_src(ex_alu_src), .ex_reg_write(ex_reg_write),
      .ex_jump(ex_jump), .ex_illegal(ex_illegal), .ex_alu_op(ex_alu_op)
   );

   id_stage_pipe #(.DATA_W(32), .REG_COUNT(32), .BYPASS_EN(0)) dut_nb (
      .clk(clk), .rst(rst), .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
      .id_ready(nb_id_ready), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
      .ex_stall(ex_stall), .ex_flush(ex_flush), .ex_valid(nb_ex_valid), .ex_pc(nb_ex_pc),
      .ex_rs_data(nb_ex_rs_data), .ex_rt_data(nb_ex_rt_data), .ex_imm(nb_ex_imm),
      .ex_rs(nb_ex_rs), .ex_rt(nb_ex_rt), .ex_dest(nb_ex_dest),
      .ex_jump_target(nb_ex_jump_target),
      .ex_branch(nb_ex_branch), .ex_mem_read(nb_ex_mem_read), .ex_mem_write(nb_ex_mem_write),
      .ex_mem_to_reg(nb_ex_mem_to_reg), .ex_alu_src(nb_ex_alu_src),
      .ex_reg_write(nb_ex_reg_write), .ex_jump(nb_ex_jump), .ex_illegal(nb_ex_illegal),
      .ex_alu_op(nb_ex_alu_op)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
         $error("check %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] r_type(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd);
      return {OP_RTYPE, rs, rt, rd, 5'd0, 6'h20};
   endfunction

   function automatic logic [31:0] i_type(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
      return {op, rs, rt, imm};
   endfunction

   initial begin
      rst = 1'b1; if_valid = 1'b1; if_instr = r_type(5'd2, 5'd3, 5'd1); if_pc = 32'h44;
      wb_en = 1'b0; wb_addr = 5'd0; wb_data = 32'h0; ex_stall = 1'b0; ex_flush = 1'b0;

      // Reset: nothing enters ID/EX while rst is high
      #1 chk("rst_ready", id_ready, 0);
      tick(); tick();
      $display("txn reset: ex_valid=%0d ex_pc=%0h", ex_valid, ex_pc);
      chk("rst_valid", ex_valid, 0);
      chk("rst_pc", ex_pc, 0);
      chk("rst_regwrite", ex_reg_write, 0);
      chk("rst_ready2", id_ready, 0);
      rst = 1'b0;

      for (int i = 1; i < 32; i++) begin
         if_instr = r_type(5'(i), 5'(i), 5'd1); if_pc = 32'(i * 4);
         tick();
         $display("txn read r%0d: rs_data=%0h rt_data=%0h", i, ex_rs_data, ex_rt_data);
         chk("clr_rs", ex_rs_data, 0);
         chk("clr_rt", ex_rt_data, 0);
         chk("clr_rsidx", ex_rs, 64'(i));
         chk("clr_valid", ex_valid, 1);
      end

      // Write-back forwarded in the same cycle as the read
      if_instr = r_type(5'd5, 5'd0, 5'd3); if_pc = 32'h100;
      wb_en = 1'b1; wb_addr = 5'd5; wb_data = 32'hDEADBEEF;
      #1 chk("byp_ready", id_ready, 1);
      tick(); wb_en = 1'b0;
      $display("txn bypass: rs_data=%0h nobypass_rs_data=%0h", ex_rs_data, nb_ex_rs_data);
      chk("byp_rs", ex_rs_data, 32'hDEADBEEF);
      chk("nobyp_rs", nb_ex_rs_data, 0);
      chk("byp_dest", ex_dest, 3);
      chk("byp_aluop", ex_alu_op, 2'b10);
      chk("byp_regwrite", ex_reg_write, 1);
      chk("byp_pc", ex_pc, 32'h100);
      if_instr = r_type(5'd5, 5'd5, 5'd9);
      tick();
      $display("txn readback r5: rs_data=%0h nb=%0h", ex_rs_data, nb_ex_rs_data);
      chk("rb_rs", ex_rs_data, 32'hDEADBEEF);
      chk("rb_rt", ex_rt_data, 32'hDEADBEEF);
      chk("rb_nb_rs", nb_ex_rs_data, 32'hDEADBEEF);

      // Writes to r0 are ignored and never forwarded
      if_instr = r_type(5'd0, 5'd0, 5'd1);
      wb_en = 1'b1; wb_addr = 5'd0; wb_data = 32'h1234;
      tick(); wb_en = 1'b0;
      $display("txn r0 write: rs_data=%0h", ex_rs_data);
      chk("r0_byp", ex_rs_data, 0);
      tick();
      chk("r0_read", ex_rs_data, 0);

      // Load-use on rs, with an unrelated write-back during the bubble
      if_instr = i_type(OP_LW, 5'd1, 5'd2, 16'd0);
      tick();
      $display("txn lw r2: mem_read=%0d dest=%0d", ex_mem_read, ex_dest);
      chk("lw_memread", ex_mem_read, 1);
      chk("lw_memtoreg", ex_mem_to_reg, 1);
      chk("lw_alusrc", ex_alu_src, 1);
      chk("lw_dest", ex_dest, 2);
      chk("lw_aluop", ex_alu_op, 0);
      if_instr = r_type(5'd2, 5'd3, 5'd4);
      wb_en = 1'b1; wb_addr = 5'd7; wb_data = 32'h77;
      #1 chk("lu_ready", id_ready, 0);
      tick(); wb_en = 1'b0;
      $display("txn load-use bubble: ex_valid=%0d id_ready=%0d", ex_valid, id_ready);
      chk("lu_bubble", ex_valid, 0);
      chk("lu_memread", ex_mem_read, 0);
      chk("lu_release", id_ready, 1);
      tick();
      $display("txn add after bubble: ex_valid=%0d dest=%0d", ex_valid, ex_dest);
      chk("lu_valid", ex_valid, 1);
      chk("lu_dest", ex_dest, 4);
      chk("lu_rs", ex_rs, 2);

      // Load-use through rt
      if_instr = i_type(OP_LW, 5'd1, 5'd2, 16'd0);
      tick();
      if_instr = r_type(5'd3, 5'd2, 5'd4);
      #1 chk("lurt_ready", id_ready, 0);
      tick();
      chk("lurt_bubble", ex_valid, 0);
      tick();
      $display("txn rt hazard resolved: ex_valid=%0d", ex_valid);
      chk("lurt_valid", ex_valid, 1);

      // addi does not read rt, so rt matching the load is no hazard
      if_instr = i_type(OP_LW, 5'd1, 5'd2, 16'd0);
      tick();
      if_instr = i_type(OP_ADDI, 5'd7, 5'd2, 16'd5);
      #1 chk("nofalse_ready", id_ready, 1);
      tick();
      $display("txn addi: ex_valid=%0d imm=%0h rs_data=%0h", ex_valid, ex_imm, ex_rs_data);
      chk("addi_valid", ex_valid, 1);
      chk("addi_imm", ex_imm, 5);
      chk("addi_dest", ex_dest, 2);
      chk("addi_r7", ex_rs_data, 32'h77);
      chk("addi_memread", ex_mem_read, 0);
      if_instr = i_type(OP_ADDI, 5'd0, 5'd6, 16'hFFFC);
      tick();
      chk("addi_negimm", ex_imm, 32'hFFFFFFFC);
      if_instr = i_type(OP_SW, 5'd1, 5'd8, 16'h10);
      tick();
      $display("txn sw: mem_write=%0d reg_write=%0d", ex_mem_write, ex_reg_write);
      chk("sw_memwrite", ex_mem_write, 1);
      chk("sw_regwrite", ex_reg_write, 0);

      // Stall holds ID/EX; flush wins over stall
      if_instr = i_type(OP_BEQ, 5'd1, 5'd2, 16'h10); if_pc = 32'h200;
      tick();
      chk("beq_branch", ex_branch, 1);
      chk("beq_aluop", ex_alu_op, 2'b01);
      ex_stall = 1'b1;
      if_instr = i_type(OP_ADDI, 5'd1, 5'd9, 16'h3); if_pc = 32'h204;
      #1 chk("stall_ready", id_ready, 0);
      for (int k = 0; k < 3; k++) begin
         tick();
         $display("txn stall %0d: ex_pc=%0h id_ready=%0d", k, ex_pc, id_ready);
         chk("stall_pc", ex_pc, 32'h200);
         chk("stall_branch", ex_branch, 1);
         chk("stall_imm", ex_imm, 32'h10);
         chk("stall_valid", ex_valid, 1);
         chk("stall_ready_k", id_ready, 0);
      end
      ex_flush = 1'b1;
      #1 chk("flush_ready", id_ready, 1);
      tick();
      $display("txn flush: ex_valid=%0d", ex_valid);
      chk("flush_valid", ex_valid, 0);
      ex_stall = 1'b0; ex_flush = 1'b0;
      tick();
      chk("post_flush_pc", ex_pc, 32'h204);

      // Illegal opcode flows through with every control bit clear
      if_instr = {6'h3F, 5'd1, 5'd2, 16'd0};
      tick();
      $display("txn illegal: ex_valid=%0d illegal=%0d", ex_valid, ex_illegal);
      chk("ill_valid", ex_valid, 1);
      chk("ill_flag", ex_illegal, 1);
      chk("ill_regwrite", ex_reg_write, 0);
      chk("ill_alusrc", ex_alu_src, 0);
      chk("ill_jump", ex_jump, 0);
      chk("ill_aluop", ex_alu_op, 0);

      if_pc = 32'h10000000; if_instr = {OP_J, 26'h40};
      tick();
      $display("txn jump: target=%0h", ex_jump_target);
      chk("j_jump", ex_jump, 1);
      chk("j_target", ex_jump_target, 32'h10000100);
      chk("j_illegal", ex_illegal, 0);

      if_valid = 1'b0;
      tick();
      chk("idle_valid", ex_valid, 0);
      if_valid = 1'b1;

      // Reset during a stall clears the pipe register and the register file
      if_instr = i_type(OP_LW, 5'd1, 5'd2, 16'd0); if_pc = 32'h300;
      tick();
      ex_stall = 1'b1;
      tick();
      chk("mid_held", ex_valid, 1);
      rst = 1'b1;
      #1 chk("mid_rst_ready", id_ready, 0);
      tick();
      rst = 1'b0; ex_stall = 1'b0;
      $display("txn mid-stall reset: ex_valid=%0d ex_pc=%0h", ex_valid, ex_pc);
      chk("mid_valid", ex_valid, 0);
      chk("mid_memread", ex_mem_read, 0);
      chk("mid_pc", ex_pc, 0);
      if_instr = r_type(5'd5, 5'd7, 5'd1);
      tick();
      chk("mid_r5", ex_rs_data, 0);
      chk("mid_r7", ex_rt_data, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
